// File: rtl/interrupt_dispatch.sv
// ============================================================================
// interrupt_dispatch
//   Interrupt dispatch sequencer: IME/EI-delay ownership, HALT wake, and the
//   5 M-cycle service sequence (wait, wait, push PC hi, push PC lo, jump).
//   Optional macro INT_CANCEL_EN: re-evaluate pending on entry to PUSH_LO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_dispatch #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int          VECTOR_STRIDE = 8
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic        I_MCYCLE,
    input  logic        I_INSTR_BOUNDARY,
    input  logic [4:0]  I_IF_DATA,
    input  logic [4:0]  I_IE_DATA,
    input  logic        I_EI,
    input  logic        I_DI,
    input  logic        I_RETI,
    input  logic        I_HALTED,
    input  logic [15:0] I_PC,
    input  logic [15:0] I_SP,
    output logic        O_BUSY,
    output logic [15:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_DATA,
    output logic        O_MEM_WE_L,
    output logic        O_SP_DEC,
    output logic        O_PC_LOAD,
    output logic [15:0] O_PC,
    output logic [4:0]  O_IF_CLEAR,
    output logic        O_IF_CLEAR_LOAD,
    output logic        O_IME,
    output logic        O_WAKE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT1   = 3'd1,
        S_WAIT2   = 3'd2,
        S_PUSH_HI = 3'd3,
        S_PUSH_LO = 3'd4,
        S_JUMP    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ime;
    logic        r_ei_pending;
    logic [2:0]  r_index;
    logic        r_index_valid;
    logic [15:0] r_pc;

    logic [4:0]  w_pending;
    logic        w_any;
    logic [2:0]  w_lowest;
    logic        w_trigger;
    logic        w_strobe;
    logic [15:0] w_vector;

    assign w_pending = I_IF_DATA & I_IE_DATA;
    assign w_any     = |w_pending;
    assign w_trigger = I_INSTR_BOUNDARY && (r_state == S_IDLE) && r_ime && w_any;
    // Strobe-qualified outputs are gated by reset so an abort takes effect in the same clock.
    assign w_strobe  = I_MCYCLE && !I_RESET;
    assign w_vector  = VECTOR_BASE + (16'(VECTOR_STRIDE) * {13'd0, r_index});

    assign O_BUSY = (r_state != S_IDLE);
    assign O_IME  = r_ime;
    assign O_WAKE = I_HALTED && w_any;

    always_comb begin
        w_lowest = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_pending[i]) w_lowest = 3'(i);
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_state       <= S_IDLE;
            r_ime         <= 1'b0;
            r_ei_pending  <= 1'b0;
            r_index       <= 3'd0;
            r_index_valid <= 1'b0;
            r_pc          <= 16'h0000;
        end else begin
            r_state <= w_state_next;

            // Later assignments take priority: boundary promotion, EI, RETI, DI, trigger.
            if (I_INSTR_BOUNDARY && r_ei_pending) begin
                r_ime        <= 1'b1;
                r_ei_pending <= 1'b0;
            end
            if (I_EI)   r_ei_pending <= 1'b1;
            if (I_RETI) r_ime        <= 1'b1;
            if (I_DI) begin
                r_ime        <= 1'b0;
                r_ei_pending <= 1'b0;
            end
            if (w_trigger) begin
                r_ime         <= 1'b0;
                r_ei_pending  <= 1'b0;
                r_index       <= w_lowest;
                r_index_valid <= 1'b1;
                r_pc          <= I_PC;
            end
`ifdef INT_CANCEL_EN
            if ((r_state == S_PUSH_HI) && I_MCYCLE) begin
                r_index       <= w_lowest;
                r_index_valid <= w_any;
            end
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        O_MEM_ADDR      = 16'h0000;
        O_MEM_DATA      = 8'h00;
        O_MEM_WE_L      = 1'b1;
        O_SP_DEC        = 1'b0;
        O_PC_LOAD       = 1'b0;
        O_PC            = 16'h0000;
        O_IF_CLEAR      = 5'b00000;
        O_IF_CLEAR_LOAD = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_trigger) w_state_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (I_MCYCLE) w_state_next = S_WAIT2;
            end
            S_WAIT2: begin
                if (I_MCYCLE) w_state_next = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                O_MEM_ADDR = I_SP - 16'd1;
                O_MEM_DATA = r_pc[15:8];
                O_MEM_WE_L = !w_strobe;
                O_SP_DEC   = w_strobe;
                if (I_MCYCLE) w_state_next = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                O_MEM_ADDR = I_SP - 16'd1;
                O_MEM_DATA = r_pc[7:0];
                O_MEM_WE_L = !w_strobe;
                O_SP_DEC   = w_strobe;
                if (I_MCYCLE) w_state_next = S_JUMP;
            end
            S_JUMP: begin
                O_PC_LOAD = w_strobe;
                if (r_index_valid) begin
                    O_PC            = w_vector;
                    O_IF_CLEAR_LOAD = w_strobe;
                    O_IF_CLEAR      = w_strobe ? (5'd1 << r_index) : 5'b00000;
                end
                if (I_MCYCLE) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_dispatch.sv
// ============================================================================
// tb_interrupt_dispatch
//   Directed-vector bench for interrupt_dispatch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_dispatch;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET, I_MCYCLE, I_INSTR_BOUNDARY;
    logic [4:0]  I_IF_DATA, I_IE_DATA;
    logic        I_EI, I_DI, I_RETI, I_HALTED;
    logic [15:0] I_PC, I_SP;
    logic        O_BUSY, O_MEM_WE_L, O_SP_DEC, O_PC_LOAD, O_IF_CLEAR_LOAD, O_IME, O_WAKE;
    logic [15:0] O_MEM_ADDR, O_PC;
    logic [7:0]  O_MEM_DATA;
    logic [4:0]  O_IF_CLEAR;

    int vecs = 0;
    int errs = 0;

    interrupt_dispatch dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_MCYCLE(I_MCYCLE),
        .I_INSTR_BOUNDARY(I_INSTR_BOUNDARY), .I_IF_DATA(I_IF_DATA), .I_IE_DATA(I_IE_DATA),
        .I_EI(I_EI), .I_DI(I_DI), .I_RETI(I_RETI), .I_HALTED(I_HALTED),
        .I_PC(I_PC), .I_SP(I_SP), .O_BUSY(O_BUSY), .O_MEM_ADDR(O_MEM_ADDR),
        .O_MEM_DATA(O_MEM_DATA), .O_MEM_WE_L(O_MEM_WE_L), .O_SP_DEC(O_SP_DEC),
        .O_PC_LOAD(O_PC_LOAD), .O_PC(O_PC), .O_IF_CLEAR(O_IF_CLEAR),
        .O_IF_CLEAR_LOAD(O_IF_CLEAR_LOAD), .O_IME(O_IME), .O_WAKE(O_WAKE)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic do_reset();
        I_RESET = 1'b1; I_MCYCLE = 1'b0; I_INSTR_BOUNDARY = 1'b0;
        I_IF_DATA = 5'b0; I_IE_DATA = 5'b0; I_EI = 1'b0; I_DI = 1'b0; I_RETI = 1'b0;
        I_HALTED = 1'b0; I_PC = 16'h0000; I_SP = 16'hFFFE;
        tick(); tick();
        I_RESET = 1'b0;
        #1;
    endtask

    task automatic pulse_reti();
        I_RETI = 1'b1; tick(); I_RETI = 1'b0; #1;
    endtask

    task automatic pulse_boundary();
        I_INSTR_BOUNDARY = 1'b1; tick(); I_INSTR_BOUNDARY = 1'b0; #1;
    endtask

    // Drives one M-cycle: a clock without strobe, then the strobe clock.
    task automatic mcycle_only();
        tick(); I_MCYCLE = 1'b1; tick(); I_MCYCLE = 1'b0; #1;
    endtask

    // Walks a dispatch from WAIT1 to IDLE, checking the push and jump outputs.
    task automatic run_dispatch(input logic [15:0] sp0, input logic [15:0] pc,
                                input logic [15:0] exp_vec, input logic [4:0] exp_clr);
        logic [15:0] sp1, sp2;
        sp1 = sp0 - 16'd1;
        sp2 = sp1 - 16'd1;
        I_SP = sp0;
        I_PC = ~pc;
        for (int m = 0; m < 2; m++) begin
            tick(); I_MCYCLE = 1'b1; #1;
            vecs++;
            if (O_BUSY !== 1'b1 || O_MEM_WE_L !== 1'b1 || O_PC_LOAD !== 1'b0) begin
                errs++;
                $display("FAIL wait%0d: busy=%b we_l=%b pc_load=%b required 1/1/0", m, O_BUSY, O_MEM_WE_L, O_PC_LOAD);
            end
            tick(); I_MCYCLE = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            tick(); #1;
            vecs++;
            if (O_MEM_ADDR !== (m == 0 ? sp1 : sp2) || O_MEM_DATA !== (m == 0 ? pc[15:8] : pc[7:0])
                || O_MEM_WE_L !== 1'b1 || O_SP_DEC !== 1'b0) begin
                errs++;
                $display("FAIL push%0d_hold: addr=%h data=%h we_l=%b dec=%b required %h/%h/1/0", m,
                         O_MEM_ADDR, O_MEM_DATA, O_MEM_WE_L, O_SP_DEC,
                         (m == 0 ? sp1 : sp2), (m == 0 ? pc[15:8] : pc[7:0]));
            end
            I_MCYCLE = 1'b1; #1;
            vecs++;
            if (O_MEM_ADDR !== (m == 0 ? sp1 : sp2) || O_MEM_DATA !== (m == 0 ? pc[15:8] : pc[7:0])
                || O_MEM_WE_L !== 1'b0 || O_SP_DEC !== 1'b1) begin
                errs++;
                $display("FAIL push%0d_strobe: addr=%h data=%h we_l=%b dec=%b required %h/%h/0/1", m,
                         O_MEM_ADDR, O_MEM_DATA, O_MEM_WE_L, O_SP_DEC,
                         (m == 0 ? sp1 : sp2), (m == 0 ? pc[15:8] : pc[7:0]));
            end
            tick(); I_MCYCLE = 1'b0;
            I_SP = (m == 0) ? sp1 : sp2;
        end
        tick(); I_MCYCLE = 1'b1; #1;
        vecs++;
        if (O_PC_LOAD !== 1'b1 || O_PC !== exp_vec || O_IF_CLEAR !== exp_clr
            || O_IF_CLEAR_LOAD !== (exp_clr != 5'b0) || O_MEM_WE_L !== 1'b1) begin
            errs++;
            $display("FAIL jump: pc_load=%b pc=%h clr=%b clr_load=%b we_l=%b required 1/%h/%b/%b/1",
                     O_PC_LOAD, O_PC, O_IF_CLEAR, O_IF_CLEAR_LOAD, O_MEM_WE_L,
                     exp_vec, exp_clr, (exp_clr != 5'b0));
        end
        tick(); I_MCYCLE = 1'b0; #1;
        vecs++;
        if (O_BUSY !== 1'b0 || O_PC_LOAD !== 1'b0 || O_IME !== 1'b0) begin
            errs++;
            $display("FAIL post_jump: busy=%b pc_load=%b ime=%b required 0/0/0", O_BUSY, O_PC_LOAD, O_IME);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (O_BUSY !== 1'b0 || O_MEM_WE_L !== 1'b1 || O_SP_DEC !== 1'b0 || O_PC_LOAD !== 1'b0
            || O_IF_CLEAR_LOAD !== 1'b0 || O_IF_CLEAR !== 5'b0 || O_MEM_ADDR !== 16'h0
            || O_MEM_DATA !== 8'h0 || O_PC !== 16'h0 || O_IME !== 1'b0 || O_WAKE !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: busy=%b we_l=%b dec=%b pcl=%b clrl=%b clr=%b addr=%h data=%h pc=%h ime=%b wake=%b required 0/1/0/0/0/0/0/0/0/0/0",
                     O_BUSY, O_MEM_WE_L, O_SP_DEC, O_PC_LOAD, O_IF_CLEAR_LOAD, O_IF_CLEAR,
                     O_MEM_ADDR, O_MEM_DATA, O_PC, O_IME, O_WAKE);
        end
    endtask

    task automatic test_basic_dispatch();
        do_reset();
        pulse_reti();
        vecs++;
        if (O_IME !== 1'b1) begin errs++; $display("FAIL reti_ime: ime=%b required 1", O_IME); end
        I_IF_DATA = 5'b00100; I_IE_DATA = 5'b11111; I_PC = 16'h1234;
        pulse_boundary();
        vecs++;
        if (O_BUSY !== 1'b1 || O_IME !== 1'b0) begin
            errs++; $display("FAIL trigger: busy=%b ime=%b required 1/0", O_BUSY, O_IME);
        end
        run_dispatch(16'hFFFE, 16'h1234, 16'h0050, 5'b00100);
    endtask

    task automatic test_priority_and_sp_wrap();
        do_reset();
        pulse_reti();
        I_IF_DATA = 5'b10010; I_IE_DATA = 5'b11111; I_PC = 16'hABCD;
        pulse_boundary();
        run_dispatch(16'h0000, 16'hABCD, 16'h0048, 5'b00010);
        // IF is still set but IME is now clear, so a boundary must not re-dispatch.
        pulse_boundary();
        vecs++;
        if (O_BUSY !== 1'b0) begin errs++; $display("FAIL no_redispatch: busy=%b required 0", O_BUSY); end
    endtask

    task automatic test_ei_delay();
        do_reset();
        I_IF_DATA = 5'b00001; I_IE_DATA = 5'b00001; I_PC = 16'h0100;
        I_EI = 1'b1; tick(); I_EI = 1'b0; #1;
        vecs++;
        if (O_IME !== 1'b0) begin errs++; $display("FAIL ei_immediate: ime=%b required 0", O_IME); end
        pulse_boundary();
        vecs++;
        if (O_BUSY !== 1'b0 || O_IME !== 1'b1) begin
            errs++; $display("FAIL ei_first_boundary: busy=%b ime=%b required 0/1", O_BUSY, O_IME);
        end
        pulse_boundary();
        vecs++;
        if (O_BUSY !== 1'b1) begin errs++; $display("FAIL ei_second_boundary: busy=%b required 1", O_BUSY); end
        run_dispatch(16'hC000, 16'h0100, 16'h0040, 5'b00001);
    endtask

    task automatic test_ei_di_same_clock();
        do_reset();
        I_IF_DATA = 5'b01000; I_IE_DATA = 5'b01000;
        I_EI = 1'b1; I_DI = 1'b1; tick(); I_EI = 1'b0; I_DI = 1'b0; #1;
        pulse_boundary();
        pulse_boundary();
        vecs++;
        if (O_IME !== 1'b0 || O_BUSY !== 1'b0) begin
            errs++; $display("FAIL ei_di: ime=%b busy=%b required 0/0", O_IME, O_BUSY);
        end
    endtask

    task automatic test_wake();
        do_reset();
        I_HALTED = 1'b1; I_IF_DATA = 5'b00001; I_IE_DATA = 5'b00001; #1;
        vecs++;
        if (O_WAKE !== 1'b1) begin errs++; $display("FAIL wake_set: wake=%b required 1", O_WAKE); end
        pulse_boundary();
        vecs++;
        if (O_BUSY !== 1'b0) begin errs++; $display("FAIL wake_no_dispatch: busy=%b required 0", O_BUSY); end
        I_IE_DATA = 5'b00010; #1;
        vecs++;
        if (O_WAKE !== 1'b0) begin errs++; $display("FAIL wake_masked: wake=%b required 0", O_WAKE); end
        I_HALTED = 1'b0;
    endtask

    task automatic test_reset_mid_dispatch();
        do_reset();
        pulse_reti();
        I_IF_DATA = 5'b00100; I_IE_DATA = 5'b11111; I_PC = 16'h1234;
        pulse_boundary();
        repeat (3) mcycle_only();
        tick(); I_MCYCLE = 1'b1; I_RESET = 1'b1; #1;
        vecs++;
        if (O_MEM_WE_L !== 1'b1 || O_SP_DEC !== 1'b0 || O_PC_LOAD !== 1'b0) begin
            errs++; $display("FAIL reset_abort: we_l=%b dec=%b pcl=%b required 1/0/0", O_MEM_WE_L, O_SP_DEC, O_PC_LOAD);
        end
        tick(); I_RESET = 1'b0; I_MCYCLE = 1'b0; #1;
        vecs++;
        if (O_BUSY !== 1'b0 || O_IME !== 1'b0) begin
            errs++; $display("FAIL reset_idle: busy=%b ime=%b required 0/0", O_BUSY, O_IME);
        end
        for (int m = 0; m < 3; m++) begin
            tick(); I_MCYCLE = 1'b1; #1;
            vecs++;
            if (O_PC_LOAD !== 1'b0 || O_MEM_WE_L !== 1'b1 || O_IF_CLEAR_LOAD !== 1'b0) begin
                errs++; $display("FAIL reset_quiet%0d: pcl=%b we_l=%b clrl=%b required 0/1/0", m, O_PC_LOAD, O_MEM_WE_L, O_IF_CLEAR_LOAD);
            end
            tick(); I_MCYCLE = 1'b0;
        end
    endtask

`ifdef INT_CANCEL_EN
    task automatic test_cancel();
        do_reset();
        pulse_reti();
        I_IF_DATA = 5'b00100; I_IE_DATA = 5'b11111; I_PC = 16'h1234; I_SP = 16'hFFFE;
        pulse_boundary();
        repeat (2) mcycle_only();
        I_IE_DATA = 5'b00000;
        repeat (2) mcycle_only();
        tick(); I_MCYCLE = 1'b1; #1;
        vecs++;
        if (O_PC !== 16'h0000 || O_PC_LOAD !== 1'b1 || O_IF_CLEAR_LOAD !== 1'b0) begin
            errs++; $display("FAIL cancel_jump: pc=%h pcl=%b clrl=%b required 0000/1/0", O_PC, O_PC_LOAD, O_IF_CLEAR_LOAD);
        end
        tick(); I_MCYCLE = 1'b0; #1;
    endtask
`endif

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: simulation time limit reached");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_basic_dispatch();
        test_priority_and_sp_wrap();
        test_ei_delay();
        test_ei_di_same_clock();
        test_wake();
        test_reset_mid_dispatch();
`ifdef INT_CANCEL_EN
        test_cancel();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interrupt_dispatch.md
Name: interrupt_dispatch

Overview:
- CPU-side consumer of the IF/IE interrupt request registers.
- At each instruction boundary it checks pending-and-enabled requests against IME; when a dispatch is due it stalls the CPU.
- It then runs the 5 M-cycle service sequence: two wait cycles, push PC high byte, push PC low byte, jump to the vector.
- On the jump it clears the serviced IF bit through the IF load path. It also owns IME, the EI delay, and wake-from-HALT.

Parameters:
- VECTOR_BASE, 16'h0040, vector address of bit 0 (V-Blank).
- VECTOR_STRIDE, 8, address step between successive interrupt bits.

Ports:
- I_CLOCK  in  1  system clock
- I_RESET  in  1  synchronous reset, active-high
- I_MCYCLE  in  1  one-clock strobe marking the last clock of each M-cycle
- I_INSTR_BOUNDARY  in  1  one-clock pulse when the CPU is about to fetch the next opcode
- I_IF_DATA  in  5  current IF register contents
- I_IE_DATA  in  5  current IE register contents
- I_EI  in  1  pulse: EI executed
- I_DI  in  1  pulse: DI executed
- I_RETI  in  1  pulse: RETI executed
- I_HALTED  in  1  CPU is in HALT
- I_PC  in  16  PC of the instruction to resume
- I_SP  in  16  live stack pointer
- O_BUSY  out  1  dispatch in progress; CPU stalls
- O_MEM_ADDR  out  16  push address
- O_MEM_DATA  out  8  push data
- O_MEM_WE_L  out  1  write enable, active-low
- O_SP_DEC  out  1  pulse: CPU decrements SP
- O_PC_LOAD  out  1  pulse: CPU loads O_PC
- O_PC  out  16  vector address
- O_IF_CLEAR  out  5  one-hot IF bit to clear
- O_IF_CLEAR_LOAD  out  1  pulse: apply O_IF_CLEAR
- O_IME  out  1  master interrupt enable
- O_WAKE  out  1  HALT exit request

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE, IME=0, ei_pending=0.
  - Outputs: O_BUSY=0, O_MEM_WE_L=1, O_SP_DEC=0, O_PC_LOAD=0, O_IF_CLEAR_LOAD=0, O_IF_CLEAR=0, O_MEM_ADDR=0, O_MEM_DATA=0, O_PC=0.
  - Reset mid-dispatch aborts immediately: no further writes, no PC load, no IF clear.
- pending = I_IF_DATA & I_IE_DATA. O_WAKE = I_HALTED & |pending, combinational and independent of IME.
- IME control:
  - DI clears IME and ei_pending in the same clock.
  - RETI sets IME in the same clock.
  - EI sets ei_pending. At the next I_INSTR_BOUNDARY, ei_pending→IME=1 and ei_pending clears. That boundary's dispatch check uses the old IME, so one instruction always executes after EI.
  - EI and DI in the same clock: DI wins.
- Dispatch trigger: at I_INSTR_BOUNDARY, if state is IDLE, IME=1 and |pending, then:
  - Go to WAIT1; O_BUSY=1 from the next clock.
  - IME cleared; ei_pending cleared.
  - Selected index = lowest set bit of pending, latched.
- FSM advances only on I_MCYCLE: IDLE→WAIT1→WAIT2→PUSH_HI→PUSH_LO→JUMP→IDLE.
- PUSH_HI: O_MEM_ADDR=I_SP-1, O_MEM_DATA=I_PC[15:8] for the whole state. O_MEM_WE_L=0 and O_SP_DEC=1 only in the clock where I_MCYCLE=1.
- PUSH_LO: same timing, with O_MEM_DATA=I_PC[7:0]. I_SP already reflects the first decrement.
- JUMP:
  - O_PC = VECTOR_BASE + index*VECTOR_STRIDE, computed 16-bit with wrap.
  - O_PC_LOAD=1, O_IF_CLEAR_LOAD=1 and O_IF_CLEAR = 1<<index, all in the I_MCYCLE clock.
  - O_BUSY drops the clock after.
- I_PC latched at trigger. Stack address SP-1 wraps modulo 2^16 (SP=0000 → write FFFF).
- Dispatch total: exactly 5 I_MCYCLE strobes from trigger to PC load.
- I_EI, I_DI, I_RETI during O_BUSY: DI/EI processed as above. RETI sets IME but never starts a nested dispatch until the next boundary after IDLE.
- New requests arriving during a dispatch remain in IF and are serviced at a later boundary.

Optional Feature:
- Macro INT_CANCEL_EN.
- Defined: pending is re-evaluated on entry to PUSH_LO, so the index is re-latched there (covers IE overwritten by the high-byte push).
  - If pending is 0 at that point: O_PC=16'h0000, O_IF_CLEAR_LOAD stays 0 at JUMP, O_PC_LOAD still pulses.
- Undefined: the index latched at trigger is used unconditionally.

Test Plan:
- IME=1, IF=5'b00100, IE=5'b11111, boundary, PC=1234, SP=FFFE → writes FFFD←12, FFFC←34; O_PC=0050; O_IF_CLEAR=00100; IME=0; 5 strobes.
- IF=5'b10010, IE=5'b11111 → index 1 wins; O_PC=0048; O_IF_CLEAR=00010.
- EI, then boundary with pending set → no dispatch at that boundary; dispatch at the following boundary.
- EI and DI in the same clock → IME stays 0; no dispatch.
- IME=0, I_HALTED=1, IF=IE=5'b00001 → O_WAKE=1; O_BUSY stays 0.
- Reset asserted during PUSH_LO → O_MEM_WE_L=1, O_PC_LOAD=0, IME=0, state IDLE next clock. With INT_CANCEL_EN, IE cleared during PUSH_HI → O_PC=0000, no IF clear.
